// File: rtl/lte_pkg.sv
// Shared LTE frame constants, scheduler state type and IQ sample layout
// for the PSS scheduling path.
package lte_pkg;

  localparam int SYMS_PER_SLOT   = 7;
  localparam int SLOTS_PER_FRAME = 20;
  localparam int PSS_SYM         = 6;
  localparam int PSS_SLOT_A      = 0;
  localparam int PSS_SLOT_B      = 10;
  localparam int GUARD_LEN       = 5;
  localparam int PSS_LEN         = 62;
  localparam int BURST_LEN       = 2 * GUARD_LEN + PSS_LEN;

  localparam int SYM_W  = 3;
  localparam int SLOT_W = 5;
  localparam int BEAT_W = 7;

  localparam logic [SYM_W-1:0]  SYM_LAST       = SYM_W'(SYMS_PER_SLOT - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(SLOTS_PER_FRAME - 1);
  localparam logic [SYM_W-1:0]  PSS_SYM_IDX    = SYM_W'(PSS_SYM);
  localparam logic [SLOT_W-1:0] PSS_SLOT_A_IDX = SLOT_W'(PSS_SLOT_A);
  localparam logic [SLOT_W-1:0] PSS_SLOT_B_IDX = SLOT_W'(PSS_SLOT_B);
  localparam logic [BEAT_W-1:0] GUARD_LAST     = BEAT_W'(GUARD_LEN - 1);
  localparam logic [BEAT_W-1:0] PSS_LAST       = BEAT_W'(PSS_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_PAYLOAD,
    ST_TRAIL
  } pss_sched_state_e;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] i;
  } iq_sample_t;

  // N_ID_2 = 3 does not exist; fall back to identity 0.
  function automatic logic [1:0] sanitize_n_id_2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd0 : v;
  endfunction

  function automatic logic is_pss_position(input logic [SYM_W-1:0]  sym,
                                           input logic [SLOT_W-1:0] slot);
    return (sym == PSS_SYM_IDX) &&
           ((slot == PSS_SLOT_A_IDX) || (slot == PSS_SLOT_B_IDX));
  endfunction

endpackage

// File: rtl/lte_frame_timer.sv
// Symbol/slot position tracker driven by the OFDM symbol strobe; exposes the
// post-tick position so the scheduler can trigger in the same cycle.
module lte_frame_timer
  import lte_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_sym_tick,
  output logic [SYM_W-1:0]  o_sym_idx,
  output logic [SLOT_W-1:0] o_slot_idx,
  output logic              o_frame_start,
  output logic              o_advance,
  output logic [SYM_W-1:0]  o_nxt_sym_idx,
  output logic [SLOT_W-1:0] o_nxt_slot_idx
);

  logic [SYM_W-1:0]  r_sym_idx;
  logic [SLOT_W-1:0] r_slot_idx;
  logic              r_frame_start;
  logic              w_advance;
  logic [SYM_W-1:0]  w_nxt_sym;
  logic [SLOT_W-1:0] w_nxt_slot;

  assign w_advance = i_enable & i_sym_tick;

  always_comb begin
    w_nxt_sym  = r_sym_idx;
    w_nxt_slot = r_slot_idx;
    if (w_advance) begin
      if (r_sym_idx == SYM_LAST) begin
        w_nxt_sym  = '0;
        w_nxt_slot = (r_slot_idx == SLOT_LAST) ? '0 : r_slot_idx + 1'b1;
      end else begin
        w_nxt_sym = r_sym_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sym_idx     <= '0;
      r_slot_idx    <= '0;
      r_frame_start <= 1'b0;
    end else if (!i_enable) begin
      r_sym_idx     <= '0;
      r_slot_idx    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_sym_idx     <= w_nxt_sym;
      r_slot_idx    <= w_nxt_slot;
      r_frame_start <= w_advance && (w_nxt_sym == '0) && (w_nxt_slot == '0);
    end
  end

  assign o_sym_idx      = r_sym_idx;
  assign o_slot_idx     = r_slot_idx;
  assign o_frame_start  = r_frame_start;
  assign o_advance      = w_advance;
  assign o_nxt_sym_idx  = w_nxt_sym;
  assign o_nxt_slot_idx = w_nxt_slot;

endmodule

// File: rtl/lte_pss_scheduler.sv
// PSS burst scheduler: frames 62 generator samples with 5 zero guards on
// each side and delivers a 72-beat burst to the resource mapper.
//   state   | meaning
//   IDLE    | waiting for a PSS trigger
//   LEAD    | emitting leading zero guards
//   PAYLOAD | passing generator samples (or zero fill after an early tlast)
//   TRAIL   | emitting trailing zero guards, tlast on the final beat
module lte_pss_scheduler
  import lte_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_sym_tick,
  input  logic [1:0]        i_n_id_2_cfg,
  input  logic              i_err_clr,
  output logic [1:0]        o_pss_n_id_2,
  input  logic [31:0]       i_s_axis_tdata,
  input  logic              i_s_axis_tvalid,
  output logic              o_s_axis_tready,
  input  logic              i_s_axis_tlast,
  output logic [31:0]       o_m_axis_tdata,
  output logic              o_m_axis_tvalid,
  input  logic              i_m_axis_tready,
  output logic              o_m_axis_tlast,
  output logic [SYM_W-1:0]  o_sym_idx,
  output logic [SLOT_W-1:0] o_slot_idx,
  output logic              o_frame_start,
  output logic              o_err_len,
  output logic              o_err_overrun
);

  logic              w_advance;
  logic [SYM_W-1:0]  w_nxt_sym;
  logic [SLOT_W-1:0] w_nxt_slot;
  logic              w_frame_start;
  logic              w_trigger;

  lte_frame_timer u_timer (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_sym_tick     (i_sym_tick),
    .o_sym_idx      (o_sym_idx),
    .o_slot_idx     (o_slot_idx),
    .o_frame_start  (w_frame_start),
    .o_advance      (w_advance),
    .o_nxt_sym_idx  (w_nxt_sym),
    .o_nxt_slot_idx (w_nxt_slot)
  );

  assign o_frame_start = w_frame_start;
  assign w_trigger     = w_advance && is_pss_position(w_nxt_sym, w_nxt_slot);

  logic       r_enable_d;
  logic [1:0] r_n_id_2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enable_d <= 1'b0;
      r_n_id_2   <= 2'd0;
    end else begin
      r_enable_d <= i_enable;
      if (w_frame_start || (i_enable && !r_enable_d)) begin
        r_n_id_2 <= sanitize_n_id_2(i_n_id_2_cfg);
      end
    end
  end

  assign o_pss_n_id_2 = r_n_id_2;

  pss_sched_state_e  r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic              r_short, w_short_nxt;
  logic              w_set_err_len;
  logic              w_set_err_ovr;
  logic              w_m_valid;
  logic              w_m_last;
  logic              w_s_ready;
  iq_sample_t        w_s_sample;
  iq_sample_t        w_m_sample;

  assign w_s_sample    = i_s_axis_tdata;
  assign w_set_err_ovr = w_trigger && (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_short_nxt   = r_short;
    w_set_err_len = 1'b0;
    w_m_sample    = '0;
    w_m_valid     = 1'b0;
    w_m_last      = 1'b0;
    w_s_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = ST_LEAD;
          w_beat_nxt  = '0;
          w_short_nxt = 1'b0;
        end
      end
      ST_LEAD: begin
        w_m_valid = 1'b1;
        if (i_m_axis_tready) begin
          if (r_beat == GUARD_LAST) begin
            w_state_nxt = ST_PAYLOAD;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        // After an early tlast the generator is cut off and zeros fill the slot.
        if (r_short) begin
          w_m_valid = 1'b1;
        end else begin
          w_m_sample = w_s_sample;
          w_m_valid  = i_s_axis_tvalid;
          w_s_ready  = i_m_axis_tready;
        end
        if (w_m_valid && i_m_axis_tready) begin
          if (r_beat == PSS_LAST) begin
            w_state_nxt = ST_TRAIL;
            w_beat_nxt  = '0;
            w_short_nxt = 1'b0;
            if (!r_short && !i_s_axis_tlast) begin
              w_set_err_len = 1'b1;
            end
          end else begin
            w_beat_nxt = r_beat + 1'b1;
            if (!r_short && i_s_axis_tlast) begin
              w_set_err_len = 1'b1;
              w_short_nxt   = 1'b1;
            end
          end
        end
      end
      ST_TRAIL: begin
        w_m_valid = 1'b1;
        w_m_last  = (r_beat == GUARD_LAST);
        if (i_m_axis_tready) begin
          if (r_beat == GUARD_LAST) begin
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = '0;
        w_short_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_short <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_short <= w_short_nxt;
    end
  end

  logic r_err_len;
  logic r_err_overrun;

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_len     <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_set_err_len) begin
        r_err_len <= 1'b1;
      end else if (i_err_clr) begin
        r_err_len <= 1'b0;
      end
      if (w_set_err_ovr) begin
        r_err_overrun <= 1'b1;
      end else if (i_err_clr) begin
        r_err_overrun <= 1'b0;
      end
    end
  end

  assign o_err_len       = r_err_len;
  assign o_err_overrun   = r_err_overrun;
  assign o_m_axis_tdata  = w_m_sample;
  assign o_m_axis_tvalid = w_m_valid;
  assign o_m_axis_tlast  = w_m_last;
  assign o_s_axis_tready = w_s_ready;

endmodule
